// File: rtl/emu_pkg.sv
// Shared types and constants for the emulation boot sequencer.
// Holds the boot FSM state type, the default config word and a width helper.
package emu_pkg;

   typedef enum logic [1:0] {
      RESET_HOLD,
      SETTLE,
      RUN,
      HALT
   } boot_state_e;

   localparam logic [7:0] DEF_CFG_SW = 8'b1000_0111;

   // Bits needed to hold 0..n-1, never less than one bit.
   function automatic int unsigned safe_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/emu_boot_sequencer_if.sv
// Control/status bundle between the harness and the boot sequencer.
// slave: sequencer side (profile/reboot/halt in, core controls and status out).
// master: harness side (drives requests, observes core controls and status).
interface emu_boot_sequencer_if #(
   parameter int unsigned CFG_W  = 8,
   parameter int unsigned PROF_W = 2,
   parameter int unsigned CNT_W  = 32
);

   logic [PROF_W-1:0] i_profile_sel;
   logic              i_reboot;
   logic              i_halt_req;
   logic              o_core_reset_n;
   logic [CFG_W-1:0]  o_cfg_sw;
   logic              o_clk_en;
   logic              o_running;
   logic              o_done;
   logic [CNT_W-1:0]  o_cycle_cnt;
   logic [7:0]        o_boot_cnt;

   modport slave (
      input  i_profile_sel, i_reboot, i_halt_req,
      output o_core_reset_n, o_cfg_sw, o_clk_en,
      output o_running, o_done, o_cycle_cnt, o_boot_cnt
   );

   modport master (
      output i_profile_sel, i_reboot, i_halt_req,
      input  o_core_reset_n, o_cfg_sw, o_clk_en,
      input  o_running, o_done, o_cycle_cnt, o_boot_cnt
   );

endinterface

// File: rtl/emu_clk_div.sv
// Free-running divider producing a one-cycle wrap strobe every CLK_DIV clocks.
// Ports: i_clk, i_reset (sync, active-high), o_wrap (high on last count).
module emu_clk_div
   import emu_pkg::*;
#(
   parameter int unsigned CLK_DIV = 1
) (
   input  logic i_clk,
   input  logic i_reset,
   output logic o_wrap
);

   localparam int unsigned DW = safe_w(CLK_DIV);
   localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] div_q;
   logic [DW-1:0] div_d;

   always_comb begin
      div_d = (div_q == LAST) ? '0 : div_q + 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

   assign o_wrap = (div_q == LAST);

endmodule

// File: rtl/emu_boot_sequencer.sv
// Emulation harness controller: core reset/config sequencing, clock-enable
// strobe, run-length/halt control and warm reboot with profile reselection.
// Ports: i_clk, i_reset (sync, active-high), bus (slave modport): profile
// select, reboot, halt request in; core reset_n, cfg switches, clk_en,
// running, done, cycle count, boot count out.
module emu_boot_sequencer
   import emu_pkg::*;
#(
   parameter int unsigned CFG_W         = 8,
   parameter int unsigned NUM_PROFILES  = 4,
   parameter int unsigned PROF_W        = 2,
   parameter logic [NUM_PROFILES*CFG_W-1:0] PROFILE_TABLE =
      {8'h00, 8'h83, 8'h07, DEF_CFG_SW},
   parameter int unsigned RESET_CYCLES  = 16,
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned CLK_DIV       = 1,
   parameter int unsigned CNT_W         = 32,
   parameter int unsigned MAX_CYCLES    = 0
) (
   input logic                 i_clk,
   input logic                 i_reset,
   emu_boot_sequencer_if.slave bus
);

   localparam int unsigned PH_N =
      (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
   localparam int unsigned PH_W = safe_w(PH_N);

   boot_state_e      state_q, state_d;
   logic [PH_W-1:0]  phase_q, phase_d;
   logic             rst_n_q, rst_n_d;
   logic [CFG_W-1:0] cfg_q, cfg_d;
   logic             pend_q, pend_d;
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic [7:0]       boot_q, boot_d;

   logic             wrap;
   logic             clk_en;
   logic [PROF_W-1:0] sel;
   logic [CFG_W-1:0] prof_cfg;
   logic [7:0]       boot_inc;

   emu_clk_div #(
      .CLK_DIV (CLK_DIV)
   ) u_div (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .o_wrap  (wrap)
   );

   assign clk_en   = wrap && (state_q != HALT) && !i_reset;
   assign sel      = bus.i_profile_sel;
   assign boot_inc = (boot_q == 8'hFF) ? boot_q : boot_q + 8'd1;

   // Out-of-range selects fall back to entry 0.
   always_comb begin
      prof_cfg = PROFILE_TABLE[CFG_W-1:0];
      for (int i = 1; i < NUM_PROFILES; i++) begin
         if (int'(sel) == i) begin
            prof_cfg = PROFILE_TABLE[i*CFG_W +: CFG_W];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      rst_n_d = rst_n_q;
      cfg_d   = cfg_q;
      pend_d  = 1'b0;
      cyc_d   = cyc_q;
      boot_d  = boot_q;
      // The profile is taken one cycle after a boot starts.
      if (pend_q) begin
         cfg_d = prof_cfg;
      end
      if (bus.i_reboot) begin
         state_d = RESET_HOLD;
         phase_d = '0;
         rst_n_d = 1'b0;
         cyc_d   = '0;
         pend_d  = 1'b1;
      end else begin
         unique case (state_q)
            RESET_HOLD: begin
               if (clk_en) begin
                  if (phase_q == PH_W'(RESET_CYCLES - 1)) begin
                     phase_d = '0;
                     if (SETTLE_CYCLES == 0) begin
                        state_d = RUN;
                        rst_n_d = 1'b1;
                        boot_d  = boot_inc;
                     end else begin
                        state_d = SETTLE;
                     end
                  end else begin
                     phase_d = phase_q + 1'b1;
                  end
               end
            end
            SETTLE: begin
               if (clk_en) begin
                  if (phase_q == PH_W'(SETTLE_CYCLES - 1)) begin
                     phase_d = '0;
                     state_d = RUN;
                     rst_n_d = 1'b1;
                     boot_d  = boot_inc;
                  end else begin
                     phase_d = phase_q + 1'b1;
                  end
               end
            end
            RUN: begin
               // A strobe in the halting cycle still counts.
               if (clk_en) begin
                  if (cyc_q != '1) begin
                     cyc_d = cyc_q + 1'b1;
                  end
                  if (MAX_CYCLES != 0 &&
                      cyc_d == CNT_W'(MAX_CYCLES)) begin
                     state_d = HALT;
                  end
               end
               if (bus.i_halt_req) begin
                  state_d = HALT;
               end
            end
            HALT: begin
            end
            default: begin
               state_d = RESET_HOLD;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= RESET_HOLD;
         phase_q <= '0;
         rst_n_q <= 1'b0;
         cfg_q   <= PROFILE_TABLE[CFG_W-1:0];
         pend_q  <= 1'b1;
         cyc_q   <= '0;
         boot_q  <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         rst_n_q <= rst_n_d;
         cfg_q   <= cfg_d;
         pend_q  <= pend_d;
         cyc_q   <= cyc_d;
         boot_q  <= boot_d;
      end
   end

   assign bus.o_core_reset_n = rst_n_q;
   assign bus.o_cfg_sw       = cfg_q;
   assign bus.o_clk_en       = clk_en;
   assign bus.o_running      = (state_q == RUN);
   assign bus.o_done         = (state_q == HALT);
   assign bus.o_cycle_cnt    = cyc_q;
   assign bus.o_boot_cnt     = boot_q;

endmodule

// File: tb/tb_emu_boot_sequencer.sv
// Scoreboard bench for emu_boot_sequencer: three configurations share one
// stimulus stream and are compared every cycle against a strobe-count model.
module tb_emu_boot_sequencer;

   typedef struct packed {
      logic        rst_n;
      logic [7:0]  cfg;
      logic        clk_en;
      logic        running;
      logic        done;
      logic [31:0] cnt;
      logic [7:0]  boots;
   } obs_t;

   typedef struct packed {
      logic [1:0] inst;
      int         cyc;
      obs_t       o;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] sel = 2'd0;
   logic       reboot = 1'b0;
   logic       halt = 1'b0;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   exp_t q[$];

   // Configurations: 0 defaults, 1 div3/R2/S0/3 profiles, 2 max 10 strobes.
   int p_div[3] = '{1, 3, 1};
   int p_r[3]   = '{16, 2, 16};
   int p_s[3]   = '{4, 0, 4};
   int p_max[3] = '{0, 0, 10};
   int p_np[3]  = '{4, 3, 4};
   logic [7:0] tab[3][4];

   int         n[3];
   bit         halted[3];
   logic [7:0] cfg[3];
   bit         pend[3];
   int         bcnt[3];
   int         tc;

   always #5 clk = ~clk;

   emu_boot_sequencer_if #(.CFG_W(8), .PROF_W(2), .CNT_W(32)) ia ();
   emu_boot_sequencer_if #(.CFG_W(8), .PROF_W(2), .CNT_W(32)) ib ();
   emu_boot_sequencer_if #(.CFG_W(8), .PROF_W(2), .CNT_W(32)) ic ();

   assign ia.i_profile_sel = sel;
   assign ia.i_reboot      = reboot;
   assign ia.i_halt_req    = halt;
   assign ib.i_profile_sel = sel;
   assign ib.i_reboot      = reboot;
   assign ib.i_halt_req    = halt;
   assign ic.i_profile_sel = sel;
   assign ic.i_reboot      = reboot;
   assign ic.i_halt_req    = halt;

   emu_boot_sequencer u_a (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (ia)
   );

   emu_boot_sequencer #(
      .NUM_PROFILES  (3),
      .PROFILE_TABLE (24'h83_07_87),
      .RESET_CYCLES  (2),
      .SETTLE_CYCLES (0),
      .CLK_DIV       (3)
   ) u_b (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (ib)
   );

   emu_boot_sequencer #(
      .MAX_CYCLES (10)
   ) u_c (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (ic)
   );

   function automatic obs_t model_out(int i);
      obs_t o;
      int rs;
      rs        = p_r[i] + p_s[i];
      o.rst_n   = (n[i] >= rs);
      o.cfg     = cfg[i];
      o.clk_en  = ((tc % p_div[i]) == p_div[i] - 1) && !halted[i] && !rst;
      o.running = (n[i] >= rs) && !halted[i];
      o.done    = halted[i];
      o.cnt     = (n[i] >= rs) ? 32'(n[i] - rs) : 32'd0;
      o.boots   = 8'(bcnt[i]);
      return o;
   endfunction

   function automatic void model_inst(int i);
      int rs;
      bit stb;
      bit in_run;
      rs = p_r[i] + p_s[i];
      if (rst) begin
         n[i]      = 0;
         halted[i] = 1'b0;
         cfg[i]    = tab[i][0];
         pend[i]   = 1'b1;
         bcnt[i]   = 0;
      end else begin
         stb    = ((tc % p_div[i]) == p_div[i] - 1) && !halted[i];
         in_run = (n[i] >= rs) && !halted[i];
         if (pend[i]) begin
            cfg[i]  = (int'(sel) < p_np[i]) ? tab[i][sel] : tab[i][0];
            pend[i] = 1'b0;
         end
         if (reboot) begin
            n[i]      = 0;
            halted[i] = 1'b0;
            pend[i]   = 1'b1;
         end else if (!halted[i]) begin
            if (stb) begin
               n[i]++;
               if (n[i] == rs) bcnt[i] = (bcnt[i] < 255) ? bcnt[i] + 1 : 255;
            end
            if (in_run && (halt ||
                (stb && p_max[i] != 0 && n[i] - rs == p_max[i])))
               halted[i] = 1'b1;
         end
      end
   endfunction

   function automatic void model_edge();
      for (int i = 0; i < 3; i++) model_inst(i);
      tc = rst ? 0 : tc + 1;
   endfunction

   function automatic obs_t actual(logic [1:0] i);
      obs_t a;
      case (i)
         2'd0: a = {ia.o_core_reset_n, ia.o_cfg_sw, ia.o_clk_en,
                    ia.o_running, ia.o_done, ia.o_cycle_cnt, ia.o_boot_cnt};
         2'd1: a = {ib.o_core_reset_n, ib.o_cfg_sw, ib.o_clk_en,
                    ib.o_running, ib.o_done, ib.o_cycle_cnt, ib.o_boot_cnt};
         default: a = {ic.o_core_reset_n, ic.o_cfg_sw, ic.o_clk_en,
                    ic.o_running, ic.o_done, ic.o_cycle_cnt, ic.o_boot_cnt};
      endcase
      return a;
   endfunction

   // Monitor: pops expected records and checks the outputs mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      obs_t a;
      while (q.size() > 0) begin
         e = q.pop_front();
         a = actual(e.inst);
         total++;
         if (a !== e.o) begin
            bad++;
            $display({"FAIL outputs dut%0d cyc=%0d got rst_n=%b cfg=%h en=%b ",
                      "run=%b done=%b cnt=%0d boots=%0d want rst_n=%b cfg=%h ",
                      "en=%b run=%b done=%b cnt=%0d boots=%0d"},
                     e.inst, e.cyc, a.rst_n, a.cfg, a.clk_en, a.running,
                     a.done, a.cnt, a.boots, e.o.rst_n, e.o.cfg, e.o.clk_en,
                     e.o.running, e.o.done, e.o.cnt, e.o.boots);
         end
      end
   end

   task automatic step();
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         e.inst = 2'(i);
         e.cyc  = cyc;
         e.o    = model_out(i);
         q.push_back(e);
      end
      @(posedge clk);
      model_edge();
      #1;
      cyc++;
   endtask

   // Called in cycle 0 after reset release; measures the reset_n rise cycle.
   task automatic wait_rise(input int exp_a, input int exp_b);
      int ra;
      int rb;
      ra = -1;
      rb = -1;
      for (int k = 0; k < 100 && (ra < 0 || rb < 0); k++) begin
         if (ra < 0 && ia.o_core_reset_n) ra = k;
         if (rb < 0 && ib.o_core_reset_n) rb = k;
         step();
      end
      total += 2;
      if (ra != exp_a) begin
         bad++;
         $display("FAIL rise_a got=%0d want=%0d", ra, exp_a);
      end
      if (rb != exp_b) begin
         bad++;
         $display("FAIL rise_b got=%0d want=%0d", rb, exp_b);
      end
   endtask

   initial begin
      tab[0] = '{8'h87, 8'h07, 8'h83, 8'h00};
      tab[1] = '{8'h87, 8'h07, 8'h83, 8'h00};
      tab[2] = '{8'h87, 8'h07, 8'h83, 8'h00};
      tc = 0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      model_edge();
      #1;
      step();
      rst = 1'b0;
      cyc = 0;
      wait_rise(20, 6);
      repeat (60) step();
      sel = 2'd2;
      reboot = 1'b1;
      halt = 1'b1;
      step();
      reboot = 1'b0;
      halt = 1'b0;
      repeat (40) step();
      sel = 2'd3;
      reboot = 1'b1;
      step();
      reboot = 1'b0;
      halt = 1'b1;
      repeat (40) step();
      halt = 1'b0;
      sel = 2'd1;
      reboot = 1'b1;
      step();
      reboot = 1'b0;
      repeat (30) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      cyc = 0;
      wait_rise(20, 6);
      repeat (10) step();
      for (int k = 0; k < 1500; k++) begin
         sel    = 2'($urandom_range(0, 3));
         reboot = ($urandom_range(0, 39) == 0);
         rst    = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 29) == 0) halt = ~halt;
         step();
      end
      rst = 1'b0;
      reboot = 1'b0;
      halt = 1'b0;
      step();
      @(negedge clk);
      #1;
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain left=%0d want=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/emu_boot_sequencer.md
Name: emu_boot_sequencer

Overview:
- Parametrised emulation harness controller that sits between the testbench clock/reset and an emulated core top (orion_pro_top class).
- Sequences core reset and configuration-switch loading, and generates a turbo clock-enable strobe at a parametrised divide ratio.
- Counts executed core cycles, supports run-length limits, halt requests and warm reboot with profile reselection.
- Replaces hard-wired cfg-switch constants with a selectable profile table.

Parameters:
- CFG_W, 8: width of the config switch word.
- NUM_PROFILES, 4: number of config profiles in the table.
- PROF_W, 2: width of the profile select; must satisfy 2**PROF_W >= NUM_PROFILES.
- PROFILE_TABLE, {8'h87,8'h07,8'h83,8'h00} (packed, entry 0 = LSBs; entry 0 = 8'b1000_0111): profile contents.
- RESET_CYCLES, 16: core reset hold length, in clock-enable strobes; must be >= 1.
- SETTLE_CYCLES, 4: cycles the config word is stable with reset still held, in strobes; may be 0.
- CLK_DIV, 1: strobe every CLK_DIV clocks; 1 = turbo, enable every clock; must be >= 1.
- CNT_W, 32: cycle counter width.
- MAX_CYCLES, 0: RUN strobe limit; 0 = unlimited.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_profile_sel  in  PROF_W  profile index; sampled on entry to RESET_HOLD.
- i_reboot  in  1  single-cycle warm reboot request.
- i_halt_req  in  1  level; stops the core while in RUN.
- o_core_reset_n  out  1  reset to the core, active-low.
- o_cfg_sw  out  CFG_W  config switches to the core.
- o_clk_en  out  1  core clock-enable strobe.
- o_running  out  1  high in RUN.
- o_done  out  1  high in HALT.
- o_cycle_cnt  out  CNT_W  RUN strobes since last boot.
- o_boot_cnt  out  8  completed boots since i_reset.

Behaviour:
- Reset (i_reset=1): state=RESET_HOLD, div=0, phase counter=0, o_core_reset_n=0, o_cfg_sw=PROFILE_TABLE[0], o_clk_en=0, o_running=0, o_done=0, o_cycle_cnt=0, o_boot_cnt=0.
- Profile latch: sampled in the first cycle after i_reset falls, and in the cycle after an accepted i_reboot. o_cfg_sw updates in the following cycle. A select >= NUM_PROFILES selects entry 0.
- Divider: div counts 0..CLK_DIV-1 and wraps; it free-runs in every state.
  - o_clk_en = (div==CLK_DIV-1) && state!=HALT && !i_reset. This is combinational from registers.
  - With CLK_DIV=1, o_clk_en=1 every cycle from the first cycle after reset.
- RESET_HOLD: o_core_reset_n=0. Counts strobes; on the RESET_CYCLES-th strobe goes to SETTLE, or to RUN if SETTLE_CYCLES=0.
- SETTLE: o_core_reset_n=0, o_cfg_sw stable. On the SETTLE_CYCLES-th strobe goes to RUN.
- RUN: o_core_reset_n=1 (registered, first cycle of RUN), o_running=1.
  - o_cycle_cnt +1 per strobe, saturating at all-ones.
  - o_boot_cnt +1 on RUN entry, saturating at 255.
- Leaving RUN:
  - If MAX_CYCLES!=0 and the increment makes o_cycle_cnt==MAX_CYCLES, go to HALT next cycle.
  - If i_halt_req=1 in RUN, go to HALT next cycle; a strobe in that same cycle is still counted.
- HALT: o_clk_en=0, o_done=1, o_running=0. o_core_reset_n stays 1 and o_cycle_cnt is frozen. Only i_reboot or i_reset leave HALT.
- i_reboot (any state): next cycle state=RESET_HOLD, phase counter=0, o_core_reset_n=0, o_cycle_cnt=0, o_done=0, o_running=0. The profile is resampled; the divider is not reset.
- Simultaneous events:
  - i_reset beats everything.
  - i_reboot beats i_halt_req and MAX_CYCLES.
  - i_halt_req in RESET_HOLD or SETTLE is ignored.
- Latency with CLK_DIV=1, counting from the first cycle with i_reset=0 as cycle 0: o_core_reset_n rises in cycle RESET_CYCLES+SETTLE_CYCLES.

Decomposition:
- Package emu_pkg holds:
  - boot_state_e enum {RESET_HOLD, SETTLE, RUN, HALT};
  - localparam function clog2-safe width helper;
  - the default profile constant DEF_CFG_SW = 8'b1000_0111.
- Sub-module emu_clk_div (params CLK_DIV): outputs div-wrap strobe, with i_clk/i_reset only.
- FSM and counters stay in emu_boot_sequencer.

Test Plan:
- Defaults (CLK_DIV=1, R=16, S=4), i_profile_sel=0, release reset:
  - o_cfg_sw=8'h87 from cycle 1;
  - o_core_reset_n rises at cycle 20;
  - o_boot_cnt=1, o_cycle_cnt increments every cycle.
- CLK_DIV=3, R=2, S=0: o_clk_en pulses at cycles 2,5,8…; o_core_reset_n rises at cycle 6; o_cycle_cnt=1 after cycle 8.
- MAX_CYCLES=10, CLK_DIV=1: o_done=1 once o_cycle_cnt=10; o_clk_en=0 thereafter; count stays 10 for 50 cycles.
- In RUN, assert i_halt_req together with i_reboot, with i_profile_sel=2:
  - next cycle RESET_HOLD, o_done=0, o_cycle_cnt=0, o_cfg_sw=8'h83;
  - o_boot_cnt=2 after re-entering RUN.
- i_profile_sel=3 with NUM_PROFILES=3 → o_cfg_sw=8'h87 (entry 0). i_halt_req held through RESET_HOLD/SETTLE → ignored, then HALT on the first RUN cycle.
- i_reset asserted mid-RUN for 1 cycle: all outputs return to reset values next cycle, and the full sequence restarts from cycle 0.
